apb_sink_buffer: RTL and testbench
==================================

# apb_sink_buffer

Per-source ingress buffer sitting directly downstream of the APB interconnect, one instance per slave (source) port. It captures the single-cycle, non-backpressurable delivery pulses the interconnect produces, including broadcast deliveries filtered by this port's subscription bit. Captured words are queued in a first-word-fall-through FIFO and drained by the local consumer over a valid/ready handshake. Loss is never silent: overflow is flagged and counted.

## Interface

- DATA_WIDTH, 32: payload width; must match the interconnect data width.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- CNT_WIDTH, 8: width of the drop counter.
- pclk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  delivery pulse from the interconnect; no ready exists on this side.
- in_data  in  DATA_WIDTH  delivered word; qualified by in_valid.
- in_is_brdcst  in  1  word arrived on the broadcast channel, not by direct address.
- brdcst_subscribed  in  1  this port's src_brdcst_subscription bit.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer accepts the head word.
- out_data  out  DATA_WIDTH  head word (fall-through).
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one eligible word was dropped.
- drop_count  out  CNT_WIDTH  saturating count of dropped eligible words.
- clr_stats  in  1  synchronous clear of overflow and drop_count.

## Operation

- Eligible delivery: in_valid && (!in_is_brdcst || brdcst_subscribed). An ineligible broadcast is ignored: no storage, no count, no flag.
- Pop: out_valid && out_ready. Removes the head word; the read pointer advances.
- Push: eligible && (level < DEPTH || pop). Writes in_data at the write pointer; the write pointer advances.
- Full with simultaneous pop: push is accepted and level stays at DEPTH.
- Drop: eligible && level == DEPTH && !pop. The word is discarded, overflow is set, and drop_count increments, saturating at all ones.
- Simultaneous push and pop at partial occupancy: level is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits, wrap naturally modulo DEPTH, and are incremented modulo 2^n.
- Occupancy states, derived from level: EMPTY (0), PARTIAL, FULL (DEPTH).
  - EMPTY to PARTIAL on push; PARTIAL to FULL on push without pop when level is DEPTH-1.
  - FULL to PARTIAL on pop without push; PARTIAL to EMPTY on pop without push when level is 1.
  - With DEPTH=2 and level 1, both transitions are reachable.
- clr_stats: overflow and drop_count clear to 0. If a drop occurs in the same cycle, the event wins: overflow=1, drop_count=1.
- out_valid = (level != 0); out_data = mem[rd_ptr]. out_data is don't-care when out_valid=0; the bench must not check it.

## Timing

- Reset, asynchronous, taking effect immediately:
  - out_valid=0, level=0, overflow=0, drop_count=0;
  - rd_ptr=wr_ptr=0;
  - memory contents are not reset and are discarded.
- Reset asserted mid-operation: all queued words are lost. The first eligible delivery after release is the first word out.
- Latency: a word pushed at edge N gives out_valid=1 with that word on out_data after edge N, so it is poppable at edge N+1. Minimum in-to-out is 1 cycle.
- No combinational path from in_* to out_*.
- out_ready affects only push acceptance and pointer updates, never out_valid or out_data in the same cycle.
- level, overflow and drop_count are registered and reflect the edge just taken.
- Accepts one word per cycle sustained: back-to-back in_valid pulses with out_ready held high never drop.

## Structure

- Shared package interconnect_pkg:
  - DATA_WIDTH default;
  - NUM_SOURCES/NUM_SINKS constants used by the interconnect;
  - typedef data_t (logic [DATA_WIDTH-1:0]);
  - typedef occ_state_e {EMPTY, PARTIAL, FULL}.
- Sub-module apb_sink_fifo_mem: DEPTH x DATA_WIDTH storage with one synchronous write port and an asynchronous read port, with no reset. All control (pointers, level, statistics, filtering) stays in apb_sink_buffer.

## Test plan

- Reset state: assert rst mid-stream with level=3 -> level=0, out_valid=0, overflow=0, drop_count=0 immediately. After release, push 0xA5 -> out_data=0xA5 next cycle.
- Fill and drop: DEPTH=4, out_ready=0, push 0x10..0x15 on 6 cycles -> level=4, overflow=1, drop_count=2. Drain order 0x10, 0x11, 0x12, 0x13.
- Full with pop: level=4, out_ready=1, push 0x20 in the same cycle -> no drop, level stays 4, 0x20 is last out.
- Broadcast filter: in_is_brdcst=1, brdcst_subscribed=0, push 0x33 -> level unchanged, drop_count unchanged. With brdcst_subscribed=1 -> 0x33 is queued.
- Statistics clear race: full, drop_count=5, clr_stats and a dropping push in the same cycle -> drop_count=1, overflow=1. Separately, drop_count=255 plus one drop -> stays 255.
- Wrap and throughput: out_ready=1, 20 back-to-back pushes of incrementing data -> zero drops, output sequence identical, level never exceeds 1.

Source files
------------

// File: rtl/interconnect_pkg.sv
// Shared definitions for the APB interconnect and its per-port sink buffers.
package interconnect_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int NUM_SOURCES = 4;
    localparam int NUM_SINKS   = 4;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_e;

endpackage

// File: rtl/apb_sink_fifo_mem.sv
// Storage array for the sink buffer: one synchronous write port and one
// asynchronous read port. All pointer and occupancy control lives in the parent.
module apb_sink_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  pclk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are meaningless until written,
    // and out_valid qualifies every read, so a reset would only add fan-out.
    always_ff @(posedge pclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_sink_buffer.sv
// Per-source ingress buffer: captures eligible interconnect delivery pulses into
// a first-word-fall-through FIFO, drained over valid/ready; overflow is counted.
module apb_sink_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_is_brdcst,
    input  logic                    brdcst_subscribed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic [CNT_WIDTH-1:0]    drop_count,
    input  logic                    clr_stats
);

    import interconnect_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    occ_state_e           occ_q, occ_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic eligible, pop, push, drop;

    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        eligible   = in_valid && (!in_is_brdcst || brdcst_subscribed);
        pop        = (occ_q != EMPTY) && out_ready;
        push       = eligible && ((occ_q != FULL) || pop);
        drop       = eligible && (occ_q == FULL) && !pop;

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear must still be recorded.
        if (clr_stats) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_stats)              drop_cnt_d = CNT_WIDTH'(1);
            else if (drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end

        if (level_d == '0)                occ_d = EMPTY;
        else if (level_d == LW'(DEPTH))   occ_d = FULL;
        else                              occ_d = PARTIAL;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            occ_q      <= EMPTY;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    apb_sink_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .pclk  (pclk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

    assign out_valid  = (occ_q != EMPTY);
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_apb_sink_buffer.sv
// Self-checking bench for apb_sink_buffer (DEPTH=4): table vectors, corner-case
// sequences and random traffic compared against a queue-based reference model.
module tb_apb_sink_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic          pclk = 1'b0;
    logic          rst  = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_is_brdcst = 1'b0;
    logic          brdcst_subscribed = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic [CW-1:0] drop_count;
    logic          clr_stats = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    int            m_cnt;

    always #5 pclk = ~pclk;

    apb_sink_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .pclk              (pclk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_is_brdcst      (in_is_brdcst),
        .brdcst_subscribed (brdcst_subscribed),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .level             (level),
        .overflow          (overflow),
        .drop_count        (drop_count),
        .clr_stats         (clr_stats)
    );

    typedef struct {
        bit          v;
        bit [DW-1:0] d;
        bit          b;
        bit          s;
        bit          r;
        bit          c;
        int          lvl;
        bit          val;
        bit          ovf;
        int          cnt;
        bit [DW-1:0] dat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_check();
        check("mdl_level",    64'(level),      64'(mq.size()));
        check("mdl_valid",    64'(out_valid),  64'(mq.size() != 0));
        check("mdl_overflow", 64'(overflow),   64'(m_ovf));
        check("mdl_drops",    64'(drop_count), 64'(m_cnt));
        if (mq.size() != 0) check("mdl_data", 64'(out_data), 64'(mq[0]));
    endtask

    // Applies one cycle of inputs, advances the model and compares after the edge.
    task automatic drive_cycle(input bit v, input logic [DW-1:0] d, input bit b,
                               input bit s, input bit r, input bit c);
        bit elig;
        in_valid = v; in_data = d; in_is_brdcst = b;
        brdcst_subscribed = s; out_ready = r; clr_stats = c;
        @(posedge pclk);
        elig = v && (!b || s);
        if (r && mq.size() != 0) void'(mq.pop_front());
        if (c) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (elig) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else begin
                m_ovf = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end
        end
        #1;
        model_check();
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] last;
        int            max_lvl;

        //            v     d      b     s     r     c     lvl val   ovf   cnt dat
        vecs[0]  = '{1'b1, 'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 'h10};
        vecs[1]  = '{1'b1, 'h11, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 'h10};
        vecs[2]  = '{1'b1, 'h12, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 0, 'h10};
        vecs[3]  = '{1'b1, 'h13, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 0, 'h10};
        vecs[4]  = '{1'b1, 'h14, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1, 'h10};
        vecs[5]  = '{1'b1, 'h15, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1, 2, 'h10};
        vecs[6]  = '{1'b0, 'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b1, 2, 'h11};
        vecs[7]  = '{1'b0, 'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 2, 'h12};
        vecs[8]  = '{1'b0, 'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 2, 'h13};
        vecs[9]  = '{1'b0, 'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 2, 'h00};
        vecs[10] = '{1'b1, 'h33, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 2, 'h00};
        vecs[11] = '{1'b1, 'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 2, 'h33};
        vecs[12] = '{1'b1, 'h44, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 2, 'h44};
        vecs[13] = '{1'b0, 'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 2, 'h00};
        vecs[14] = '{1'b0, 'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 'h00};

        model_reset();
        #12;
        check("rst_level",    64'(level),      64'(0));
        check("rst_valid",    64'(out_valid),  64'(0));
        check("rst_overflow", 64'(overflow),   64'(0));
        check("rst_drops",    64'(drop_count), 64'(0));
        @(negedge pclk);
        rst = 1'b0;

        // Table: fill and drop, drain order, broadcast filter, clear.
        for (int i = 0; i < 15; i++) begin
            drive_cycle(vecs[i].v, vecs[i].d, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d_level", i),    64'(level),      64'(vecs[i].lvl));
            check($sformatf("vec%0d_valid", i),    64'(out_valid),  64'(vecs[i].val));
            check($sformatf("vec%0d_overflow", i), 64'(overflow),   64'(vecs[i].ovf));
            check($sformatf("vec%0d_drops", i),    64'(drop_count), 64'(vecs[i].cnt));
            if (vecs[i].val) check($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].dat));
        end

        // Asynchronous reset mid-stream at level 3 with overflow set.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, DW'(32'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_rst_level", 64'(level), 64'(3));
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_level",    64'(level),      64'(0));
        check("async_rst_valid",    64'(out_valid),  64'(0));
        check("async_rst_overflow", 64'(overflow),   64'(0));
        check("async_rst_drops",    64'(drop_count), 64'(0));
        @(negedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        drive_cycle(1'b1, 'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", 64'(out_valid), 64'(1));
        check("post_rst_data",  64'(out_data),  64'(32'hA5));
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full with simultaneous pop and push.
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, DW'(32'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 'h20, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fullpop_level", 64'(level),      64'(4));
        check("fullpop_drops", 64'(drop_count), 64'(0));
        last = '0;
        for (int i = 0; i < 4; i++) begin
            last = out_data;
            drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("fullpop_last_out", 64'(last), 64'(32'h20));

        // Statistics clear racing a drop, then saturation.
        for (int i = 0; i < 9; i++) drive_cycle(1'b1, DW'(32'h70 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("five_drops", 64'(drop_count), 64'(5));
        drive_cycle(1'b1, 'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_race_drops",    64'(drop_count), 64'(1));
        check("clr_race_overflow", 64'(overflow),   64'(1));
        for (int i = 0; i < 254; i++) drive_cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_reach", 64'(drop_count), 64'(255));
        drive_cycle(1'b1, 'h99, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_hold", 64'(drop_count), 64'(255));
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_alone_drops",    64'(drop_count), 64'(0));
        check("clr_alone_overflow", 64'(overflow),   64'(0));
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Wrap and sustained throughput.
        max_lvl = 0;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b0, 1'b1, 1'b0);
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        check("tp_max_level", 64'(max_lvl),    64'(1));
        check("tp_drops",     64'(drop_count), 64'(0));
        check("tp_last_data", 64'(out_data),   64'(32'h113));
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            drive_cycle(1'($urandom_range(0, 2) != 0), DW'($urandom),
                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 30) == 0));
        end

        idle_cycle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
